rf_tx_serializer: RTL and testbench

- Domain-2 transmit stage directly downstream of the register file.
- Consumes the register file's rf_tx_start, rf_tx_mode, rf_power_domain and rf_tx_data controls.
- Serialises one framed 32-bit word onto a single-wire RF output, as NRZ or Manchester.
- Returns a one-cycle rf_tx_done pulse to the register file when the frame completes.

---
 rtl/rf_tx_pkg.sv | 25 ++
 rtl/rf_tx_serializer_line_encoder.sv | 33 +++
 rtl/rf_tx_serializer.sv | 156 +++++++++++++++
 tb/tb_rf_tx_serializer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_tx_pkg.sv
// Shared definitions for the RF transmit serializer: FSM states, frame geometry, line modes.
package rf_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PREAMBLE = 3'd1,
      ST_DATA     = 3'd2,
      ST_PARITY   = 3'd3,
      ST_DONE     = 3'd4,
      ST_ABORT    = 3'd5
   } tx_state_e;

   localparam int FRAME_BITS = 41;
   localparam int PRE_BITS   = 8;
   localparam int DATA_BITS  = 32;

   localparam logic MODE_NRZ = 1'b0;
   localparam logic MODE_MAN = 1'b1;

   // States in which a frame bit is being driven onto the line.
   function automatic logic is_on_line(input tx_state_e s);
      return (s == ST_PREAMBLE) || (s == ST_DATA) || (s == ST_PARITY);
   endfunction

endpackage

// File: rtl/rf_tx_serializer_line_encoder.sv
// Registered NRZ / Manchester line encoder; tx_out is a flop so the RF line never glitches.
module rf_line_encoder
   import rf_tx_pkg::*;
(
   input  logic clk,
   input  logic resetn,
   input  logic en,
   input  logic bit_val,
   input  logic half,
   input  logic mode,
   output logic tx_out
);

   logic tx_out_d;
   logic tx_out_q;

   // Manchester (802.3): '1' is low then high, '0' is high then low.
   always_comb begin
      tx_out_d = 1'b0;
      if (en) begin
         if (mode == MODE_MAN) tx_out_d = ~(bit_val ^ half);
         else                  tx_out_d = bit_val;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) tx_out_q <= 1'b0;
      else         tx_out_q <= tx_out_d;
   end

   assign tx_out = tx_out_q;

endmodule

// File: rtl/rf_tx_serializer.sv
// Frames a 32-bit word (preamble, data, even parity) onto a single-wire RF line.
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | line low, waiting for a powered start edge
// PREAMBLE | sending the 8-bit sync pattern, MSB first
// DATA     | sending the latched 32-bit payload, MSB first
// PARITY   | sending the even-parity bit
// DONE     | one cycle, pulses rf_tx_done
// ABORT    | one cycle after power loss, pulses tx_abort
module rf_tx_serializer
   import rf_tx_pkg::*;
#(
   parameter int         CLKS_PER_BIT = 4,
   parameter logic [7:0] PREAMBLE     = 8'hA5
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        rf_tx_start,
   input  logic        rf_tx_mode,
   input  logic        rf_power_domain,
   input  logic [31:0] rf_tx_data,
   output logic        rf_tx_done,
   output logic        tx_out,
   output logic        tx_en,
   output logic        tx_busy,
   output logic        tx_abort
);

   localparam int                CYC_W     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(CLKS_PER_BIT - 1);
   localparam logic [CYC_W-1:0]  CYC_HALF  = CYC_W'(CLKS_PER_BIT / 2);
   localparam logic [5:0]        PRE_LAST  = 6'(PRE_BITS - 1);
   localparam logic [5:0]        DATA_LAST = 6'(DATA_BITS - 1);

   tx_state_e        state_q, state_d;
   logic             start_q;
   logic [CYC_W-1:0] cyc_q, cyc_d;
   logic [5:0]       idx_q, idx_d;
   logic [31:0]      data_q, data_d;
   logic             mode_q, mode_d;
   logic             par_q, par_d;

   logic launch;
   logic bit_end;
   logic line_bit;
   logic line_en;
   logic line_half;

   assign launch  = rf_tx_start & ~start_q & rf_power_domain & (state_q == ST_IDLE);
   assign bit_end = (cyc_q == CYC_LAST);

   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      idx_d   = idx_q;
      data_d  = data_q;
      mode_d  = mode_q;
      par_d   = par_q;
      case (state_q)
         ST_IDLE: begin
            cyc_d = '0;
            idx_d = '0;
            if (launch) begin
               state_d = ST_PREAMBLE;
               data_d  = rf_tx_data;
               mode_d  = rf_tx_mode;
               par_d   = ^rf_tx_data;
            end
         end
         ST_PREAMBLE, ST_DATA, ST_PARITY: begin
            // Power loss outranks a coincident end of the last bit.
            if (!rf_power_domain) begin
               state_d = ST_ABORT;
               cyc_d   = '0;
               idx_d   = '0;
            end else if (bit_end) begin
               cyc_d = '0;
               idx_d = idx_q + 6'd1;
               if (state_q == ST_PREAMBLE && idx_q == PRE_LAST) begin
                  state_d = ST_DATA;
                  idx_d   = '0;
               end else if (state_q == ST_DATA && idx_q == DATA_LAST) begin
                  state_d = ST_PARITY;
                  idx_d   = '0;
               end else if (state_q == ST_PARITY) begin
                  state_d = ST_DONE;
                  idx_d   = '0;
               end
            end else begin
               cyc_d = cyc_q + CYC_W'(1);
            end
         end
         ST_DONE, ST_ABORT: begin
            state_d = ST_IDLE;
            cyc_d   = '0;
            idx_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
            cyc_d   = '0;
            idx_d   = '0;
         end
      endcase
   end

   // The encoder registers its output, so it is fed the next-cycle bit.
   always_comb begin
      line_bit = 1'b0;
      case (state_d)
         ST_PREAMBLE: line_bit = PREAMBLE[3'(3'd7 - idx_d[2:0])];
         ST_DATA:     line_bit = data_d[5'(5'd31 - idx_d[4:0])];
         ST_PARITY:   line_bit = par_d;
         default:     line_bit = 1'b0;
      endcase
   end

   assign line_en   = is_on_line(state_d);
   assign line_half = (cyc_d >= CYC_HALF);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         start_q <= 1'b0;
         cyc_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         mode_q  <= MODE_NRZ;
         par_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= rf_tx_start;
         cyc_q   <= cyc_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         mode_q  <= mode_d;
         par_q   <= par_d;
      end
   end

   rf_line_encoder u_line_encoder (
      .clk     (clk),
      .resetn  (resetn),
      .en      (line_en),
      .bit_val (line_bit),
      .half    (line_half),
      .mode    (mode_d),
      .tx_out  (tx_out)
   );

   assign tx_en      = is_on_line(state_q);
   assign tx_busy    = is_on_line(state_q);
   assign rf_tx_done = (state_q == ST_DONE);
   assign tx_abort   = (state_q == ST_ABORT);

endmodule

// File: tb/tb_rf_tx_serializer.sv
// Directed bench for rf_tx_serializer at CLKS_PER_BIT=4, preamble 8'hA5.
module tb_rf_tx_serializer;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        rf_tx_start = 1'b0;
   logic        rf_tx_mode = 1'b0;
   logic        rf_power_domain = 1'b1;
   logic [31:0] rf_tx_data = '0;
   logic        rf_tx_done;
   logic        tx_out;
   logic        tx_en;
   logic        tx_busy;
   logic        tx_abort;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   rf_tx_serializer dut (
      .clk             (clk),
      .resetn          (resetn),
      .rf_tx_start     (rf_tx_start),
      .rf_tx_mode      (rf_tx_mode),
      .rf_power_domain (rf_power_domain),
      .rf_tx_data      (rf_tx_data),
      .rf_tx_done      (rf_tx_done),
      .tx_out          (tx_out),
      .tx_en           (tx_en),
      .tx_busy         (tx_busy),
      .tx_abort        (tx_abort)
   );

   // Expected 164-cycle line waveform, first line cycle in the MSB.
   function automatic logic [163:0] exp_frame(input logic [31:0] d, input logic m);
      logic [40:0]  bits;
      logic [163:0] r;
      logic         v;
      bits = {8'hA5, d, ^d};
      r    = '0;
      for (int b = 0; b < 41; b++) begin
         v = bits[40-b];
         for (int p = 0; p < 4; p++)
            r[163-(b*4+p)] = m ? ((p < 2) ? ~v : v) : v;
      end
      return r;
   endfunction

   // Observes one frame from the cycle after launch through cycle N+165.
   task automatic capture_frame(output logic [163:0] line, output int done_at,
                                output int done_cnt, output int en_bad);
      line = '0; done_at = -1; done_cnt = 0; en_bad = 0;
      for (int k = 1; k <= 165; k++) begin
         @(negedge clk);
         if (k <= 164) begin
            line[164-k] = tx_out;
            if (tx_en !== 1'b1 || tx_busy !== 1'b1) en_bad++;
         end
         if (rf_tx_done === 1'b1) begin
            done_cnt++;
            if (done_at < 0) done_at = k;
         end
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({rf_tx_done, tx_out, tx_en, tx_busy, tx_abort} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b want 00000",
                  {rf_tx_done, tx_out, tx_en, tx_busy, tx_abort});
      end
      resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_nrz();
      logic [163:0] line;
      int done_at, done_cnt, en_bad;
      rf_tx_data = 32'h0000_0001; rf_tx_mode = 1'b0;
      @(negedge clk); rf_tx_start = 1'b1;
      #1;
      n_checks++;
      if (tx_en !== 1'b0) begin n_fail++; $display("FAIL nrz_en_launch_cycle: got %b want 0", tx_en); end
      capture_frame(line, done_at, done_cnt, en_bad);
      n_checks++;
      if (line !== {32'hF0F0_0F0F, 124'b0, 8'hFF}) begin
         n_fail++; $display("FAIL nrz_line: got %h want %h", line, {32'hF0F0_0F0F, 124'b0, 8'hFF});
      end
      n_checks++;
      if (done_at !== 165) begin n_fail++; $display("FAIL nrz_done_cycle: got %0d want 165", done_at); end
      n_checks++;
      if (en_bad !== 0) begin n_fail++; $display("FAIL nrz_en_busy: got %0d low cycles want 0", en_bad); end
      n_checks++;
      if ({tx_en, tx_busy, tx_out} !== 3'b000) begin
         n_fail++; $display("FAIL nrz_done_state: got %b want 000", {tx_en, tx_busy, tx_out});
      end
      @(negedge clk); rf_tx_start = 1'b0;
      n_checks++;
      if ({rf_tx_done, tx_busy} !== 2'b00) begin
         n_fail++; $display("FAIL nrz_done_single_pulse: got %b want 00", {rf_tx_done, tx_busy});
      end
   endtask

   task automatic test_manchester();
      logic [163:0] line;
      int done_at, done_cnt, en_bad;
      rf_tx_data = 32'hFFFF_FFFF; rf_tx_mode = 1'b1;
      @(negedge clk); rf_tx_start = 1'b1;
      capture_frame(line, done_at, done_cnt, en_bad);
      n_checks++;
      if (line !== {32'h3C3C_C3C3, {32{4'h3}}, 4'hC}) begin
         n_fail++; $display("FAIL man_line: got %h want %h", line, {32'h3C3C_C3C3, {32{4'h3}}, 4'hC});
      end
      n_checks++;
      if (done_at !== 165 || done_cnt !== 1) begin
         n_fail++; $display("FAIL man_done: got at %0d count %0d want at 165 count 1", done_at, done_cnt);
      end
      n_checks++;
      if (en_bad !== 0) begin n_fail++; $display("FAIL man_en_busy: got %0d low cycles want 0", en_bad); end
      rf_tx_start = 1'b0;
   endtask

   task automatic test_abort();
      logic [163:0] line;
      int done_at, done_cnt, en_bad, late;
      rf_tx_data = 32'hCAFE_F00D; rf_tx_mode = 1'b0;
      @(negedge clk); rf_tx_start = 1'b1;
      repeat (114) @(negedge clk);
      n_checks++;
      if (tx_en !== 1'b1) begin n_fail++; $display("FAIL abort_pre_en: got %b want 1", tx_en); end
      rf_power_domain = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({tx_abort, tx_out, tx_en, tx_busy, rf_tx_done} !== 5'b10000) begin
         n_fail++; $display("FAIL abort_cycle: got %b want 10000",
                            {tx_abort, tx_out, tx_en, tx_busy, rf_tx_done});
      end
      late = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (rf_tx_done !== 1'b0 || tx_abort !== 1'b0 || tx_busy !== 1'b0) late++;
      end
      n_checks++;
      if (late !== 0) begin n_fail++; $display("FAIL abort_quiet_after: got %0d active cycles want 0", late); end
      rf_power_domain = 1'b1; rf_tx_start = 1'b0;
      rf_tx_data = 32'h8000_0003;
      @(negedge clk); rf_tx_start = 1'b1;
      capture_frame(line, done_at, done_cnt, en_bad);
      n_checks++;
      if (line !== exp_frame(32'h8000_0003, 1'b0) || done_at !== 165) begin
         n_fail++; $display("FAIL abort_fresh_frame: got %h done %0d want %h done 165",
                            line, done_at, exp_frame(32'h8000_0003, 1'b0));
      end
      rf_tx_start = 1'b0;
   endtask

   task automatic test_start_handling();
      int cnt;
      rf_tx_data = 32'h0000_00A0; rf_tx_mode = 1'b0;
      @(negedge clk); rf_tx_start = 1'b1;
      cnt = 0;
      repeat (500) begin @(negedge clk); if (rf_tx_done === 1'b1) cnt++; end
      n_checks++;
      if (cnt !== 1) begin n_fail++; $display("FAIL start_held: got %0d done pulses want 1", cnt); end
      rf_tx_start = 1'b0;
      @(negedge clk); rf_tx_start = 1'b1;
      cnt = 0;
      for (int k = 1; k <= 400; k++) begin
         @(negedge clk);
         if (rf_tx_done === 1'b1) cnt++;
         if (k == 40) rf_tx_start = 1'b0;
         if (k == 50) rf_tx_start = 1'b1;
      end
      n_checks++;
      if (cnt !== 1) begin n_fail++; $display("FAIL start_edge_while_busy: got %0d done pulses want 1", cnt); end
      rf_tx_start = 1'b0; rf_power_domain = 1'b0;
      @(negedge clk); rf_tx_start = 1'b1;
      cnt = 0;
      repeat (20) begin @(negedge clk); if (tx_busy !== 1'b0 || tx_en !== 1'b0) cnt++; end
      n_checks++;
      if (cnt !== 0) begin n_fail++; $display("FAIL start_unpowered: got %0d busy cycles want 0", cnt); end
      rf_tx_start = 1'b0; rf_power_domain = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      logic [163:0] line;
      int done_at, done_cnt, en_bad;
      rf_tx_data = 32'h5555_AAAA; rf_tx_mode = 1'b1;
      @(negedge clk); rf_tx_start = 1'b1;
      repeat (80) @(negedge clk);
      #2; resetn = 1'b0; rf_tx_start = 1'b0;
      #1;
      n_checks++;
      if ({rf_tx_done, tx_out, tx_en, tx_busy, tx_abort} !== 5'b0) begin
         n_fail++; $display("FAIL async_reset_outputs: got %b want 00000",
                            {rf_tx_done, tx_out, tx_en, tx_busy, tx_abort});
      end
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk); rf_tx_start = 1'b1;
      capture_frame(line, done_at, done_cnt, en_bad);
      n_checks++;
      if (line !== exp_frame(32'h5555_AAAA, 1'b1) || done_at !== 165) begin
         n_fail++; $display("FAIL async_reset_fresh_frame: got %h done %0d want %h done 165",
                            line, done_at, exp_frame(32'h5555_AAAA, 1'b1));
      end
      rf_tx_start = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [163:0] line;
      int done_at, done_cnt, en_bad;
      rf_tx_data = 32'h1234_5678; rf_tx_mode = 1'b0;
      @(negedge clk); rf_tx_start = 1'b1;
      fork
         capture_frame(line, done_at, done_cnt, en_bad);
         begin
            repeat (40) @(negedge clk);
            rf_tx_data = 32'h0; rf_tx_mode = 1'b1; rf_tx_start = 1'b0;
         end
      join
      n_checks++;
      if (line !== exp_frame(32'h1234_5678, 1'b0)) begin
         n_fail++; $display("FAIL latch_line: got %h want %h", line, exp_frame(32'h1234_5678, 1'b0));
      end
      n_checks++;
      if (line[3:0] !== 4'hF) begin n_fail++; $display("FAIL latch_parity: got %h want f", line[3:0]); end
      n_checks++;
      if (done_at !== 165) begin n_fail++; $display("FAIL latch_done_cycle: got %0d want 165", done_at); end
      @(negedge clk);
      rf_tx_data = 32'h0000_00FF; rf_tx_mode = 1'b0; rf_tx_start = 1'b1;
      capture_frame(line, done_at, done_cnt, en_bad);
      n_checks++;
      if (en_bad !== 0 || line !== exp_frame(32'h0000_00FF, 1'b0) || done_at !== 165) begin
         n_fail++; $display("FAIL back_to_back: got %h done %0d gaps %0d want %h done 165 gaps 0",
                            line, done_at, en_bad, exp_frame(32'h0000_00FF, 1'b0));
      end
      rf_tx_start = 1'b0;
   endtask

   initial begin
      test_reset();
      test_nrz();
      test_manchester();
      test_abort();
      test_start_handling();
      test_async_reset();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
